// File: rtl/serial_bus_loader_if.sv
// Bus and serial signals shared between the serial loader (master) and the
// memory / host side (slave).
interface serial_bus_loader_if;
    logic        rx;
    logic        tx;
    logic        hold;
    logic [15:0] addr;
    logic [7:0]  odata;
    logic [7:0]  idata;
    logic        rd;
    logic        wr_n;
    logic        busy;

    modport master (
        input  rx, idata,
        output tx, hold, addr, odata, rd, wr_n, busy
    );

    modport slave (
        output rx, idata,
        input  tx, hold, addr, odata, rd, wr_n, busy
    );
endinterface

// File: rtl/serial_bus_loader.sv
// Serial (8N1) bus initiator: takes the memory bus from the CPU so a host can
// load and dump memory with W/R/H/G byte commands.
module serial_bus_loader #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned TIMEOUT_CLKS = 2500000
) (
    input logic                 clk,
    input logic                 reset,
    serial_bus_loader_if.master bus_io
);

    localparam logic [15:0] BitLast     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HalfLast    = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CLKS - 1);

    localparam logic [7:0] CmdW    = 8'h57;
    localparam logic [7:0] CmdR    = 8'h52;
    localparam logic [7:0] CmdH    = 8'h48;
    localparam logic [7:0] CmdG    = 8'h47;
    localparam logic [7:0] AckByte = 8'h2E;
    localparam logic [7:0] NakByte = 8'h3F;

    // ---------------- UART RX ----------------
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e   rx_state_q, rx_state_d;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_valid_q, rx_valid_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_s1_q    <= bus_io.rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_valid_d = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                // Re-check the start bit mid-bit; a high line here was a glitch.
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_valid_d = rx_s2_q;
                    rx_state_d = RxIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ---------------- UART TX ----------------
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_pend_q, tx_pend_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_load, tx_done;

    assign tx_load = (tx_state_q == TxIdle) && tx_pend_q;
    assign tx_done = (tx_state_q == TxStop) && (tx_cnt_q == BitLast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        unique case (tx_state_q)
            TxIdle: begin
                if (tx_pend_q) begin
                    tx_sh_d    = tx_byte_q;
                    tx_cnt_d   = '0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TxData: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TxStop;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TxStop: begin
                if (tx_cnt_q == BitLast) tx_state_d = TxIdle;
                else                     tx_cnt_d   = tx_cnt_q + 16'd1;
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    assign bus_io.tx = (tx_state_q == TxStart) ? 1'b0 :
                       (tx_state_q == TxData)  ? tx_sh_q[0] : 1'b1;

    // ---------------- Command FSM ----------------
    typedef enum logic [3:0] {
        StIdle, StAddrH, StAddrL, StLen, StWdata,
        StWstrobe, StRstrobe, StRcapt, StRsend, StReply
    } cmd_state_e;

    cmd_state_e  state_q, state_d;
    logic        hold_q, hold_d;
    logic        is_wr_q, is_wr_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  odata_q, odata_d;
    logic [8:0]  count_q, count_d;
    logic [31:0] timer_q, timer_d;
    logic        waiting, reply_req;
    logic [7:0]  reply_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            hold_q    <= 1'b0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            odata_q   <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            tx_pend_q <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            odata_q   <= odata_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            tx_pend_q <= tx_pend_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    assign waiting = (state_q == StAddrH) || (state_q == StAddrL) ||
                     (state_q == StLen)   || (state_q == StWdata);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        odata_d    = odata_q;
        count_d    = count_q;
        tx_pend_d  = tx_load ? 1'b0 : tx_pend_q;
        tx_byte_d  = tx_byte_q;
        timer_d    = (waiting && !rx_valid_q) ? timer_q + 32'd1 : 32'd0;
        reply_req  = 1'b0;
        reply_byte = AckByte;
        unique case (state_q)
            StIdle: begin
                if (rx_valid_q) begin
                    case (rx_sh_q)
                        CmdW, CmdR: begin
                            hold_d  = 1'b1;
                            is_wr_d = (rx_sh_q == CmdW);
                            state_d = StAddrH;
                        end
                        CmdH: begin
                            hold_d    = 1'b1;
                            reply_req = 1'b1;
                        end
                        CmdG: begin
                            hold_d    = 1'b0;
                            reply_req = 1'b1;
                        end
                        default: begin
                            reply_req  = 1'b1;
                            reply_byte = NakByte;
                        end
                    endcase
                end
            end
            StAddrH: if (rx_valid_q) begin
                addr_d[15:8] = rx_sh_q;
                state_d      = StAddrL;
            end
            StAddrL: if (rx_valid_q) begin
                addr_d[7:0] = rx_sh_q;
                state_d     = StLen;
            end
            StLen: if (rx_valid_q) begin
                count_d = (rx_sh_q == 8'd0) ? 9'd256 : {1'b0, rx_sh_q};
                state_d = is_wr_q ? StWdata : StRstrobe;
            end
            StWdata: if (rx_valid_q) begin
                odata_d = rx_sh_q;
                state_d = StWstrobe;
            end
            StWstrobe: begin
                addr_d  = addr_q + 16'd1;
                count_d = count_q - 9'd1;
                if (count_q == 9'd1) reply_req = 1'b1;
                else                 state_d   = StWdata;
            end
            StRstrobe: state_d = StRcapt;
            StRcapt: begin
                tx_pend_d = 1'b1;
                tx_byte_d = bus_io.idata;
                state_d   = StRsend;
            end
            StRsend: if (tx_done) begin
                addr_d  = addr_q + 16'd1;
                count_d = count_q - 9'd1;
                state_d = (count_q == 9'd1) ? StIdle : StRstrobe;
            end
            StReply: if (tx_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Inter-byte timeout abandons the command but keeps addr and hold.
        if (waiting && !rx_valid_q && (timer_q == TimeoutLast)) begin
            reply_req  = 1'b1;
            reply_byte = NakByte;
        end
        if (reply_req) begin
            state_d   = StReply;
            tx_pend_d = 1'b1;
            tx_byte_d = reply_byte;
        end
    end

    always_comb begin
        bus_io.rd   = (state_q == StRstrobe);
        bus_io.wr_n = (state_q != StWstrobe);
        bus_io.busy = (state_q != StIdle);
    end

    assign bus_io.hold  = hold_q;
    assign bus_io.addr  = addr_q;
    assign bus_io.odata = odata_q;

endmodule

// File: tb/tb_serial_bus_loader.sv
// Scoreboard bench for serial_bus_loader: expected bus strobes and TX bytes are
// queued as commands are sent and popped as the DUT produces them.
module tb_serial_bus_loader;

    localparam int unsigned Cpb    = 8;
    localparam int unsigned ToClks = 2000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_bus_loader_if bus_if ();

    serial_bus_loader #(
        .CLKS_PER_BIT(Cpb),
        .TIMEOUT_CLKS(ToClks)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b1;

    logic [7:0]  exp_tx[$];
    logic [23:0] exp_wr[$];
    logic [15:0] exp_rd[$];

    logic [7:0]  mem [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: read data appears the clk after rd.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (!bus_if.wr_n) mem[bus_if.addr] <= bus_if.odata;
        if (bus_if.rd) bus_if.idata <= mem[bus_if.addr];
    end

    always @(negedge clk) begin
        if (reset) begin
            if (!bus_if.wr_n) begin
                if (exp_wr.size() == 0) check_eq("wr_unexpected", exp_wr.size(), 1);
                else check_eq("wr_addr_data", {bus_if.addr, bus_if.odata}, exp_wr.pop_front());
            end
            if (bus_if.rd) begin
                check_eq("wr_n_during_rd", bus_if.wr_n, 1);
                if (exp_rd.size() == 0) check_eq("rd_unexpected", exp_rd.size(), 1);
                else check_eq("rd_addr", bus_if.addr, exp_rd.pop_front());
            end
        end
    end

    initial begin : tx_mon
        logic [7:0] b;
        logic       stop;
        forever begin
            @(negedge bus_if.tx);
            repeat (Cpb / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (Cpb) @(posedge clk);
                #1 b[i] = bus_if.tx;
            end
            repeat (Cpb) @(posedge clk);
            #1 stop = bus_if.tx;
            if (mon_en) begin
                if (exp_tx.size() == 0) check_eq("tx_unexpected", exp_tx.size(), 1);
                else check_eq("tx_byte", {stop, b}, {1'b1, exp_tx.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus_if.rx = 1'b0;
        repeat (Cpb) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            bus_if.rx = b[i];
            repeat (Cpb) @(posedge clk);
        end
        bus_if.rx = stop_bit;
        repeat (Cpb) @(posedge clk);
        bus_if.rx = 1'b1;
        if (!stop_bit) repeat (Cpb) @(posedge clk);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((bus_if.busy || exp_tx.size() != 0 || exp_wr.size() != 0 ||
                exp_rd.size() != 0) && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        check_eq(tag, exp_tx.size() + exp_wr.size() + exp_rd.size() + 32'(bus_if.busy), 0);
    endtask

    function automatic logic [7:0] pattern(input int i);
        return 8'(i * 7 + 3);
    endfunction

    initial begin
        bus_if.rx = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx", bus_if.tx, 1);
        check_eq("rst_hold", bus_if.hold, 0);
        check_eq("rst_addr", bus_if.addr, 0);
        check_eq("rst_odata", bus_if.odata, 0);
        check_eq("rst_rd", bus_if.rd, 0);
        check_eq("rst_wr_n", bus_if.wr_n, 1);
        check_eq("rst_busy", bus_if.busy, 0);
        reset = 1'b1;
        repeat (4 * Cpb) @(posedge clk);

        exp_tx.push_back(8'h2E);
        send_byte(8'h48, 1'b1);
        wait_idle("h_done", 400);
        check_eq("h_hold", bus_if.hold, 1);

        exp_tx.push_back(8'h2E);
        send_byte(8'h47, 1'b1);
        wait_idle("g_done", 400);
        check_eq("g_hold", bus_if.hold, 0);

        exp_tx.push_back(8'h3F);
        send_byte(8'h78, 1'b1);
        wait_idle("x_done", 400);
        check_eq("x_hold_low", bus_if.hold, 0);

        exp_wr.push_back({16'h1FFE, 8'hAA});
        exp_wr.push_back({16'h1FFF, 8'hBB});
        exp_wr.push_back({16'h2000, 8'hCC});
        exp_tx.push_back(8'h2E);
        foreach (exp_wr[i]) ;
        send_byte(8'h57, 1'b1);
        send_byte(8'h1F, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        wait_idle("w_done", 600);
        check_eq("w_hold", bus_if.hold, 1);
        check_eq("w_addr_end", bus_if.addr, 16'h2001);
        check_eq("w_mem_2000", mem[16'h2000], 8'hCC);

        exp_tx.push_back(8'h3F);
        send_byte(8'h78, 1'b1);
        wait_idle("x2_done", 400);
        check_eq("x_hold_high", bus_if.hold, 1);

        preload(16'hFFFF, 8'h11);
        preload(16'h0000, 8'h22);
        exp_rd.push_back(16'hFFFF);
        exp_rd.push_back(16'h0000);
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h22);
        send_byte(8'h52, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_idle("r_wrap_done", 1000);
        check_eq("r_wrap_addr", bus_if.addr, 16'h0001);

        for (int i = 0; i < 256; i++) begin
            preload(16'(i), pattern(i));
            exp_rd.push_back(16'(i));
            exp_tx.push_back(pattern(i));
        end
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_idle("r256_done", 40000);
        check_eq("r256_addr", bus_if.addr, 16'h0100);

        exp_tx.push_back(8'h3F);
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_idle("timeout_done", ToClks + 400);
        check_eq("timeout_busy", bus_if.busy, 0);
        check_eq("timeout_hold", bus_if.hold, 1);
        check_eq("timeout_addr", bus_if.addr, 16'h0000);

        send_byte(8'h47, 1'b0);
        repeat (20 * Cpb) @(posedge clk);
        #1;
        check_eq("badstop_busy", bus_if.busy, 0);
        check_eq("badstop_hold", bus_if.hold, 1);

        bus_if.rx = 1'b0;
        repeat (Cpb / 4) @(posedge clk);
        bus_if.rx = 1'b1;
        repeat (20 * Cpb) @(posedge clk);
        #1;
        check_eq("glitch_busy", bus_if.busy, 0);

        exp_tx.push_back(8'h2E);
        send_byte(8'h48, 1'b1);
        wait_idle("recover_done", 400);

        begin
            int n = 0;
            mon_en = 1'b0;
            exp_rd.push_back(16'h0010);
            send_byte(8'h52, 1'b1);
            send_byte(8'h00, 1'b1);
            send_byte(8'h10, 1'b1);
            send_byte(8'h01, 1'b1);
            while (bus_if.tx && n < 2000) begin
                @(posedge clk);
                #1 n++;
            end
            check_eq("rst_mid_tx_started", bus_if.tx, 0);
            check_eq("rst_mid_rd_seen", exp_rd.size(), 0);
            repeat (3 * Cpb) @(posedge clk);
            #1 reset = 1'b0;
            #1;
            check_eq("rst_mid_tx", bus_if.tx, 1);
            check_eq("rst_mid_hold", bus_if.hold, 0);
            check_eq("rst_mid_rd", bus_if.rd, 0);
            check_eq("rst_mid_wr_n", bus_if.wr_n, 1);
            check_eq("rst_mid_busy", bus_if.busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_bus_loader.md
Name: serial_bus_loader

Overview:
- Host-side bus initiator that takes the memory bus away from the i8080 so a PC can load and dump memory over an 8N1 serial link.
- Contains its own UART RX/TX and a byte-command FSM, and drives the same addr/odata/rd/wr_n bus the CPU drives.
- While hold is high, the top level muxes this block onto the bus and keeps the CPU in reset.
- Serves as the debug and boot-load path alongside the mc6850 console.

Parameters:
- CLKS_PER_BIT, 217: clocks per serial bit (25 MHz / 115200).
- TIMEOUT_CLKS, 2500000: inter-byte timeout inside a command (100 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- rx  in  1  serial in, idle high, asynchronous to clk
- tx  out  1  serial out, idle high
- hold  out  1  bus owned by loader; CPU must be held in reset
- addr  out  16  bus address
- odata  out  8  bus write data
- idata  in  8  bus read data, valid the clk after rd
- rd  out  1  read strobe, one clk
- wr_n  out  1  write strobe, active low, one clk
- busy  out  1  command in progress (FSM not in IDLE)

Behaviour:
- Reset values: tx=1, hold=0, addr=0, odata=0, rd=0, wr_n=1, busy=0. FSM goes to IDLE, UART RX/TX go idle, pending TX byte is cleared.
- UART RX:
  - rx passes through a 2-flop synchroniser.
  - A falling edge starts a frame. Start bit is re-checked at CLKS_PER_BIT/2; if high, treat as a glitch and return to idle.
  - Data bits are sampled LSB first every CLKS_PER_BIT from mid-start.
  - Stop bit must be 1, otherwise the byte is discarded silently.
  - A good byte gives a one-clk rx_valid pulse.
- UART TX:
  - Frame is start(0), 8 data bits LSB first, stop(1), each CLKS_PER_BIT clocks.
  - The FSM loads a byte only when TX is idle; tx_done pulses when the stop bit ends.
- Command FSM states: IDLE, ADDR_H, ADDR_L, LEN, WDATA, WSTROBE, RSTROBE, RCAPT, RSEND, REPLY.
  - IDLE on 'W'(0x57) or 'R'(0x52): set hold=1, go to ADDR_H.
  - IDLE on 'H'(0x48): set hold=1, reply '.'(0x2E).
  - IDLE on 'G'(0x47): set hold=0, reply '.'.
  - IDLE on any other byte: reply '?'(0x3F); hold is unchanged.
  - ADDR_H, then ADDR_L, load addr. LEN loads count; 0 means 256, so count is 9 bits.
  - Write path: WDATA waits for a byte and latches it to odata. WSTROBE drives wr_n=0 for exactly one clk with addr/odata stable. Next clk: addr+1 (16-bit wrap, 0xFFFF to 0x0000), count-1. Return to WDATA until count=0, then reply '.'.
  - Read path: RSTROBE drives rd=1 for one clk. RCAPT latches idata on the following clk. RSEND transmits the byte and waits for tx_done. Then addr+1, count-1; repeat until count=0. No trailing reply.
  - REPLY transmits one byte, waits for tx_done, goes to IDLE.
- Timeout: in ADDR_H, ADDR_L, LEN or WDATA, a timer counts clks since the last rx byte. At TIMEOUT_CLKS, abort and reply '?'; addr/hold keep their current values.
- Bytes received while the FSM is not waiting for a byte (strobe, send or reply states) are dropped. Hosts must not pipeline ahead of responses.
- rd and wr_n are never active in the same clk. addr is stable for the whole strobe and capture cycle.
- hold changes only via W, R, H or G, and rises at least one clk before the first strobe.
- An asynchronous reset in mid-command aborts immediately: hold drops to 0 and a partial TX frame is truncated, leaving tx=1.

Test Plan:
- Send 'H' -> hold=1, tx returns 0x2E. Send 'G' -> hold=0, tx returns 0x2E. Send 'x' -> 0x3F, hold unchanged.
- Send 'W',0x1F,0xFE,0x03,0xAA,0xBB,0xCC -> three single-clk wr_n pulses at 0x1FFE/0xAA, 0x1FFF/0xBB, 0x2000/0xCC, then reply 0x2E, hold=1.
- Memory model preloaded 0xFFFF=0x11, 0x0000=0x22. Send 'R',0xFF,0xFF,0x02 -> rd at 0xFFFF then 0x0000 (wrap), tx returns 0x11, 0x22.
- Send 'R',0x00,0x00,0x00 -> exactly 256 rd pulses, addr ends at 0x0100, 256 bytes returned.
- Send 'W',0x00 then idle for TIMEOUT_CLKS -> reply 0x3F, no wr_n pulse, FSM back in IDLE (busy=0).
- Frame with stop bit=0, or a 1/4-bit rx glitch -> no rx_valid, no reply. Assert reset mid 'R' transmit -> tx=1, hold=0, rd=0, wr_n=1 immediately.
